crc_rx_check: RTL and testbench
===============================

CRC_RX_CHECK -- requirements
Module: crc_rx_check

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 1024, meaning number of payload bytes per frame; legal range 1..1024.
REQ-002 SHALL have port clk50m  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port chk_start  input  1  single-cycle pulse that arms reception of one frame.
REQ-005 SHALL have port rx_data  input  8  incoming byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data is valid.
REQ-007 SHALL have port rx_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  memory write strobe.
REQ-009 SHALL have port mem_addr  output  10  memory write address.
REQ-010 SHALL have port mem_wdata  output  8  memory write data.
REQ-011 SHALL have port crc_value  output  16  running CRC over the payload bytes received so far.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port chk_done  output  1  single-cycle pulse when the comparison result is valid.
REQ-014 SHALL have port crc_ok  output  1  level: last frame CRC matched.
REQ-015 SHALL have port crc_err  output  1  level: last frame CRC mismatched.

Function
REQ-016 Frame format SHALL be PAYLOAD_LEN payload bytes, then CRC high byte, then CRC low byte.
REQ-017 A byte SHALL transfer only in a cycle with rx_valid=1 and rx_ready=1; rx_valid=0 cycles are stalls of unlimited length with no state change.
REQ-018 The FSM SHALL have the states IDLE, RECV_DATA, RECV_CRC_HI, RECV_CRC_LO, COMPARE, and DONE.
REQ-019 IDLE: on chk_start, the FSM SHALL clear the address counter to 0, load the CRC register with 0xFFFF, and go to RECV_DATA.
REQ-020 RECV_DATA: each transfer SHALL write rx_data to the current address and update the CRC; after transfer number PAYLOAD_LEN the FSM SHALL go to RECV_CRC_HI, otherwise the address SHALL increment by 1.
REQ-021 The address counter SHALL never wrap: the last written address is PAYLOAD_LEN-1, and no increment occurs past it.
REQ-022 RECV_CRC_HI: a transfer SHALL latch rx_data as rx_crc[15:8] and go to RECV_CRC_LO, with no memory write and no CRC update.
REQ-023 RECV_CRC_LO: a transfer SHALL latch rx_data as rx_crc[7:0] and go to COMPARE, with no memory write.
REQ-024 COMPARE: for one cycle the FSM SHALL evaluate crc_value==rx_crc, then go to DONE.
REQ-025 On entry to DONE, the block SHALL pulse chk_done for one cycle and set exactly one of crc_ok / crc_err; both are held until the next chk_start or rst.
REQ-026 DONE: on chk_start the block SHALL clear crc_ok and crc_err, restart as in REQ-019, and go to RECV_DATA.
REQ-027 In the non-receiving states, rx_ready SHALL be low.
REQ-028 rx_ready SHALL be 1 in RECV_DATA, RECV_CRC_HI, and RECV_CRC_LO, driven combinationally from state.
REQ-029 busy SHALL be 1 in every state except IDLE and DONE.
REQ-030 chk_start SHALL be ignored while busy=1.
REQ-031 The CRC SHALL be CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR; one full byte is processed per transfer cycle.
REQ-032 crc_value SHALL update on the clock edge of the transfer.
REQ-033 mem_we, mem_addr and mem_wdata SHALL be registered, appearing one cycle after the transfer.
REQ-034 mem_we SHALL be high for exactly one cycle per payload byte.
REQ-035 When mem_we=0, mem_addr SHALL hold the last value and mem_wdata is don't-care.
REQ-036 If rx_valid=1 in IDLE or DONE, the byte SHALL be neither accepted nor written.
REQ-037 If chk_start coincides with rx_valid=1 in IDLE or DONE, the byte SHALL not be accepted; the first accepted byte arrives on the next cycle.

Reset
REQ-038 rst=1 at a clock edge SHALL force the state to IDLE, the address counter and mem_addr to 0, and crc_value to 0xFFFF.
REQ-039 rst=1 at a clock edge SHALL force rx_ready, mem_we, busy, chk_done, crc_ok and crc_err to 0.
REQ-040 rst mid-frame SHALL abandon the frame with no chk_done, and no memory write SHALL occur in the cycle following the reset edge.
REQ-041 rst SHALL take priority over chk_start and rx_valid in the same cycle.

Verification
REQ-042 Scenario: PAYLOAD_LEN=9, chk_start, bytes "123456789" then 0x29, 0xB1 back-to-back -> 9 writes to addresses 0..8, crc_value=0x29B1, one chk_done pulse, crc_ok=1, crc_err=0.
REQ-043 Scenario: same frame with a CRC low byte of 0xB0 -> chk_done pulse, crc_ok=0, crc_err=1, held until the next chk_start.
REQ-044 Scenario: same frame with 3-cycle rx_valid gaps between every byte -> identical writes and result, with mem_we count = 9.
REQ-045 Scenario: PAYLOAD_LEN=1024, incrementing payload -> last write at address 1023, no write to address 0 after address 1023, and the next 2 bytes are not written to memory.
REQ-046 Scenario: rst asserted after 5 payload bytes -> all outputs at their reset values next cycle, no chk_done; a following good frame passes.
REQ-047 Scenario: chk_start while busy, and chk_start in DONE -> the first is ignored; the second clears crc_ok/crc_err and restarts at address 0 with crc_value=0xFFFF.

Source files
------------

// File: rtl/crc_rx_check.sv
// ---------------------------------------------------------------------------
// crc_rx_check
//   Receives one frame per chk_start: PAYLOAD_LEN payload bytes followed by a
//   big-endian CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection,
//   no final XOR). Payload bytes are written to an external memory, starting
//   at address 0. The CRC carried in the frame is compared with the locally
//   computed one, and the result is reported.
//
// Ports
//   clk50m     in   system clock (rising edge)
//   rst        in   synchronous active-high reset
//   chk_start  in   pulse: arm reception of one frame (ignored while busy)
//   rx_data    in   [7:0] incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte accepted this cycle when rx_valid=1
//   mem_we     out  registered memory write strobe
//   mem_addr   out  [9:0] registered write address (held when mem_we=0)
//   mem_wdata  out  [7:0] registered write data
//   crc_value  out  [15:0] running CRC over payload bytes received so far
//   busy       out  frame in progress
//   chk_done   out  one-cycle pulse when crc_ok/crc_err become valid
//   crc_ok     out  level: last frame CRC matched
//   crc_err    out  level: last frame CRC mismatched
// ---------------------------------------------------------------------------
module crc_rx_check #(
    parameter int PAYLOAD_LEN = 1024
) (
    input  logic        clk50m,
    input  logic        rst,
    input  logic        chk_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [15:0] crc_value,
    output logic        busy,
    output logic        chk_done,
    output logic        crc_ok,
    output logic        crc_err
);

    localparam logic [9:0] LAST_ADDR = 10'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV_DATA,
        RECV_CRC_HI,
        RECV_CRC_LO,
        COMPARE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_addr;
    logic [15:0] r_crc;
    logic [15:0] r_rx_crc;
    logic        w_xfer;
    logic        w_last;
    logic        w_start;

    // One whole byte per call: XOR the byte into the top of the register,
    // then shift out eight bits, folding the polynomial in on each carry.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign w_xfer    = rx_valid & rx_ready;
    assign w_last    = (r_addr == LAST_ADDR);
    assign w_start   = chk_start & ((r_state == IDLE) | (r_state == DONE));
    assign crc_value = r_crc;

    // State register
    always_ff @(posedge clk50m) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            IDLE: begin
                if (chk_start) w_next = RECV_DATA;
            end
            RECV_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer && w_last) w_next = RECV_CRC_HI;
            end
            RECV_CRC_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = RECV_CRC_LO;
            end
            RECV_CRC_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) w_next = COMPARE;
            end
            COMPARE: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                if (chk_start) w_next = RECV_DATA;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: address counter, CRC, memory port, result flags
    always_ff @(posedge clk50m) begin
        if (rst) begin
            r_addr    <= 10'd0;
            r_crc     <= 16'hFFFF;
            r_rx_crc  <= 16'h0000;
            mem_we    <= 1'b0;
            mem_addr  <= 10'd0;
            mem_wdata <= 8'h00;
            chk_done  <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            chk_done <= 1'b0;
            if (w_start) begin
                r_addr  <= 10'd0;
                r_crc   <= 16'hFFFF;
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
            end
            case (r_state)
                RECV_DATA: begin
                    if (w_xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= rx_data;
                        r_crc     <= crc16_byte(r_crc, rx_data);
                        // Counter parks on the last address instead of wrapping.
                        if (!w_last) r_addr <= r_addr + 10'd1;
                    end
                end
                RECV_CRC_HI: if (w_xfer) r_rx_crc[15:8] <= rx_data;
                RECV_CRC_LO: if (w_xfer) r_rx_crc[7:0]  <= rx_data;
                COMPARE: begin
                    // Registered here so the flags and the pulse appear
                    // together on the first DONE cycle.
                    chk_done <= 1'b1;
                    crc_ok   <= (r_crc == r_rx_crc);
                    crc_err  <= (r_crc != r_rx_crc);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_rx_check.sv
module tb_crc_rx_check;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;
    typedef struct {
        logic        ok;
        logic [15:0] crc;
    } res_t;

    logic clk50m = 1'b0;
    always #5 clk50m = ~clk50m;

    // DUT A: 9-byte payload
    logic        a_rst, a_start, a_valid;
    logic [7:0]  a_data;
    logic        a_ready, a_we, a_busy, a_done, a_ok, a_err;
    logic [9:0]  a_addr;
    logic [7:0]  a_wdata;
    logic [15:0] a_crc;

    // DUT B: 1024-byte payload
    logic        b_rst, b_start, b_valid;
    logic [7:0]  b_data;
    logic        b_ready, b_we, b_busy, b_done, b_ok, b_err;
    logic [9:0]  b_addr;
    logic [7:0]  b_wdata;
    logic [15:0] b_crc;

    crc_rx_check #(.PAYLOAD_LEN(9)) u_a (
        .clk50m(clk50m), .rst(a_rst), .chk_start(a_start), .rx_data(a_data),
        .rx_valid(a_valid), .rx_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .crc_value(a_crc), .busy(a_busy), .chk_done(a_done),
        .crc_ok(a_ok), .crc_err(a_err)
    );

    crc_rx_check #(.PAYLOAD_LEN(1024)) u_b (
        .clk50m(clk50m), .rst(b_rst), .chk_start(b_start), .rx_data(b_data),
        .rx_valid(b_valid), .rx_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .crc_value(b_crc), .busy(b_busy), .chk_done(b_done),
        .crc_ok(b_ok), .crc_err(b_err)
    );

    int total = 0;
    int bad   = 0;
    int wra_cnt = 0;

    wr_t  qa[$], qb[$];
    res_t ra[$], rb[$];
    wr_t  wa_t, wb_t;
    res_t xa_t, xb_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    // Reference CRC, bit-serial over the input bits
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Monitors
    always @(negedge clk50m) begin
        if (a_we) begin
            wra_cnt++;
            if (qa.size() == 0) unexpected("A write", {12'd0, a_addr, a_wdata});
            else begin
                wa_t = qa.pop_front();
                check("A wr addr", {22'd0, a_addr}, {22'd0, wa_t.a});
                check("A wr data", {24'd0, a_wdata}, {24'd0, wa_t.d});
            end
        end
        if (a_done) begin
            if (ra.size() == 0) unexpected("A chk_done", {31'd0, a_ok});
            else begin
                xa_t = ra.pop_front();
                check("A crc_ok",    {31'd0, a_ok},  {31'd0, xa_t.ok});
                check("A crc_err",   {31'd0, a_err}, {31'd0, !xa_t.ok});
                check("A crc_value", {16'd0, a_crc}, {16'd0, xa_t.crc});
            end
        end
    end

    always @(negedge clk50m) begin
        if (b_we) begin
            if (qb.size() == 0) unexpected("B write", {12'd0, b_addr, b_wdata});
            else begin
                wb_t = qb.pop_front();
                check("B wr addr", {22'd0, b_addr}, {22'd0, wb_t.a});
                check("B wr data", {24'd0, b_wdata}, {24'd0, wb_t.d});
            end
        end
        if (b_done) begin
            if (rb.size() == 0) unexpected("B chk_done", {31'd0, b_ok});
            else begin
                xb_t = rb.pop_front();
                check("B crc_ok",    {31'd0, b_ok},  {31'd0, xb_t.ok});
                check("B crc_err",   {31'd0, b_err}, {31'd0, !xb_t.ok});
                check("B crc_value", {16'd0, b_crc}, {16'd0, xb_t.crc});
            end
        end
    end

    // All stimulus tasks begin and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic send_byte(input bit b, input logic [7:0] d, input int gap);
        bit acc;
        int n;
        n = 0;
        if (b) begin b_valid = 1'b1; b_data = d; end
        else   begin a_valid = 1'b1; a_data = d; end
        do begin
            acc = b ? b_ready : a_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) unexpected("send_byte timeout", {24'd0, d});
        if (b) b_valid = 1'b0; else a_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic pulse_start(input bit b);
        if (b) b_start = 1'b1; else a_start = 1'b1;
        tick();
        if (b) b_start = 1'b0; else a_start = 1'b0;
    endtask

    task automatic expect_frame(input bit b, input byte_q_t p, input logic ok, input logic [15:0] crc);
        res_t r;
        wr_t  w;
        for (int i = 0; i < p.size(); i++) begin
            w.a = 10'(i);
            w.d = p[i];
            if (b) qb.push_back(w); else qa.push_back(w);
        end
        r.ok  = ok;
        r.crc = crc;
        if (b) rb.push_back(r); else ra.push_back(r);
    endtask

    task automatic wait_result(input bit b);
        int n;
        n = 0;
        while ((b ? rb.size() : ra.size()) != 0 && n < 20) begin
            tick();
            n++;
        end
        check("result arrived", b ? rb.size() : ra.size(), 0);
        check("writes drained", b ? qb.size() : qa.size(), 0);
    endtask

    task automatic send_frame(input bit b, input byte_q_t p, input logic [7:0] hi,
                              input logic [7:0] lo, input int gap, input bit do_start);
        if (do_start) pulse_start(b);
        foreach (p[i]) send_byte(b, p[i], gap);
        send_byte(b, hi, gap);
        send_byte(b, lo, gap);
        wait_result(b);
    endtask

    task automatic check_reset_a();
        check("rst rx_ready",  {31'd0, a_ready}, 0);
        check("rst busy",      {31'd0, a_busy},  0);
        check("rst mem_we",    {31'd0, a_we},    0);
        check("rst chk_done",  {31'd0, a_done},  0);
        check("rst crc_ok",    {31'd0, a_ok},    0);
        check("rst crc_err",   {31'd0, a_err},   0);
        check("rst crc_value", {16'd0, a_crc},   32'h0000_FFFF);
        check("rst mem_addr",  {22'd0, a_addr},  0);
    endtask

    byte_q_t p9, p5, p1k;
    logic [15:0] crc1k;
    int c0;

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        p5 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        check_reset_a();

        // Good frame, back-to-back
        expect_frame(0, p9, 1'b1, 16'h29B1);
        send_frame(0, p9, 8'h29, 8'hB1, 0, 1);
        repeat (3) tick();
        check("good held ok",  {31'd0, a_ok},   1);
        check("good held err", {31'd0, a_err},  0);
        check("DONE busy",     {31'd0, a_busy}, 0);
        check("DONE rx_ready", {31'd0, a_ready}, 0);

        // Bytes offered in DONE without a start are not taken
        a_valid = 1'b1; a_data = 8'h55;
        repeat (3) tick();
        a_valid = 1'b0;

        // Bad CRC low byte
        expect_frame(0, p9, 1'b0, 16'h29B1);
        send_frame(0, p9, 8'h29, 8'hB0, 0, 1);
        repeat (5) tick();
        check("bad held ok",  {31'd0, a_ok},  0);
        check("bad held err", {31'd0, a_err}, 1);

        // Start in DONE with a byte offered the same cycle; then 3-cycle gaps
        expect_frame(0, p9, 1'b1, 16'h29B1);
        a_valid = 1'b1; a_data = 8'hEE; a_start = 1'b1;
        tick();
        a_start = 1'b0; a_valid = 1'b0;
        check("restart ok clr",  {31'd0, a_ok},   0);
        check("restart err clr", {31'd0, a_err},  0);
        check("restart crc",     {16'd0, a_crc},  32'h0000_FFFF);
        check("restart busy",    {31'd0, a_busy}, 1);
        check("restart no wr",   {31'd0, a_we},   0);
        c0 = wra_cnt;
        send_frame(0, p9, 8'h29, 8'hB1, 3, 0);
        check("gap write count", wra_cnt - c0, 9);

        // chk_start while busy is ignored
        expect_frame(0, p9, 1'b1, 16'h29B1);
        pulse_start(0);
        for (int i = 0; i < 3; i++) send_byte(0, p9[i], 0);
        pulse_start(0);
        for (int i = 3; i < 9; i++) send_byte(0, p9[i], 0);
        send_byte(0, 8'h29, 0);
        send_byte(0, 8'hB1, 0);
        wait_result(0);

        // Reset after 5 payload bytes, with start and valid also asserted
        pulse_start(0);
        foreach (p5[i]) begin
            wa_t.a = 10'(i);
            wa_t.d = p5[i];
            qa.push_back(wa_t);
        end
        foreach (p5[i]) send_byte(0, p5[i], 0);
        a_rst = 1'b1; a_start = 1'b1; a_valid = 1'b1; a_data = 8'hAA;
        tick();
        a_rst = 1'b0; a_start = 1'b0; a_valid = 1'b0;
        check_reset_a();
        repeat (6) tick();
        check("post-rst drained", qa.size(), 0);
        expect_frame(0, p9, 1'b1, 16'h29B1);
        send_frame(0, p9, 8'h29, 8'hB1, 0, 1);

        // 1024-byte frame, incrementing payload
        crc1k = 16'hFFFF;
        for (int i = 0; i < 1024; i++) begin
            p1k.push_back(8'(i));
            crc1k = ref_crc(crc1k, 8'(i));
        end
        expect_frame(1, p1k, 1'b1, crc1k);
        send_frame(1, p1k, crc1k[15:8], crc1k[7:0], 0, 1);
        check("B last addr held", {22'd0, b_addr}, 32'd1023);
        check("B ok level",       {31'd0, b_ok},   1);

        repeat (5) tick();
        check("end qa", qa.size(), 0);
        check("end ra", ra.size(), 0);
        check("end qb", qb.size(), 0);
        check("end rb", rb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
